cs_resolve_pipe: RTL and testbench

//   Converts carry-save (sum, carry) vectors from a CSA 4:2 compressor tree into plain binary.

---
 rtl/cs_resolve_pipe_if.sv | 23 ++
 rtl/cs_resolve_pipe.sv | 136 +++++++++++++
 tb/tb_cs_resolve_pipe.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cs_resolve_pipe_if.sv
// Handshake bundle for cs_resolve_pipe: carry-save input beat in, resolved binary beat out.
interface cs_resolve_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_cout;

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_data, out_cout
  );

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_data, out_cout
  );
endinterface

// File: rtl/cs_resolve_pipe.sv
// Pipelined carry-propagate adder turning (sum, carry) redundant form into binary, SEG bits per stage.
// Optional unsigned saturation on overflow when CS_RESOLVE_SAT_EN is defined.
module cs_resolve_pipe #(
  parameter int W   = 32,
  parameter int SEG = 8
) (
  input logic            clk,
  input logic            rst,
  cs_resolve_pipe_if.slave bus
);

  localparam int NSTG = W / SEG;

`ifdef CS_RESOLVE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  if (W % SEG != 0) begin : g_bad_seg
    $error("cs_resolve_pipe: W must be a multiple of SEG");
  end

  function automatic logic [SEG:0] seg_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input int idx);
    logic [SEG-1:0] sa;
    logic [SEG-1:0] sb;
    sa = a[idx*SEG +: SEG];
    sb = b[idx*SEG +: SEG];
    return {1'b0, sa} + {1'b0, sb} + {{SEG{1'b0}}, c};
  endfunction

  function automatic logic [W-1:0] put_seg(input logic [W-1:0] a, input logic [SEG-1:0] s,
                                           input int idx);
    logic [W-1:0] r;
    r = a;
    r[idx*SEG +: SEG] = s;
    return r;
  endfunction

  function automatic logic [W-1:0] sat_fn(input logic [W-1:0] d, input logic cout);
    return (SAT_EN && cout) ? {W{1'b1}} : d;
  endfunction

  // Inputs presented to stage k: src_*[0] is the bus, src_*[k] is stage k-1's register.
  logic [NSTG-1:0]        rdy;
  logic [NSTG-1:0]        vld_all;
  logic [NSTG-1:0]        src_v;
  logic [NSTG-1:0]        src_msb;
  logic [NSTG-1:0]        src_cin;
  logic [NSTG-1:0][W-1:0] src_acc;
  logic [NSTG-1:0][W-1:0] src_cry;

  assign src_v[0]   = bus.in_valid;
  assign src_acc[0] = bus.in_sum;
  assign src_cry[0] = {bus.in_carry[W-2:0], 1'b0};
  assign src_msb[0] = bus.in_carry[W-1];
  assign src_cin[0] = 1'b0;
  assign bus.in_ready = rdy[0];

  // A stage may load unless it and every stage after it is full while the sink stalls.
  always_comb begin
    logic full;
    full = 1'b1;
    rdy  = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      full   = full & vld_all[k];
      rdy[k] = bus.out_ready | !full;
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [SEG:0]  seg;
    logic          vld_p;
    logic [W-1:0]  acc_p;
    logic          cin_p;

    assign seg        = seg_add(src_acc[k], src_cry[k], src_cin[k], k);
    assign vld_all[k] = vld_p;

    if (k < NSTG - 1) begin : g_mid
      logic [W-1:0] cry_p;
      logic         msb_p;

      // ---- stage k boundary: segment k resolved, carry out forwarded ----
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p <= 1'b0;
          acc_p <= '0;
          cin_p <= 1'b0;
          cry_p <= '0;
          msb_p <= 1'b0;
        end else if (rdy[k]) begin
          vld_p <= src_v[k];
          if (src_v[k]) begin
            acc_p <= put_seg(src_acc[k], seg[SEG-1:0], k);
            cin_p <= seg[SEG];
            cry_p <= src_cry[k];
            msb_p <= src_msb[k];
          end
        end
      end

      assign src_v[k+1]   = vld_p;
      assign src_acc[k+1] = acc_p;
      assign src_cry[k+1] = cry_p;
      assign src_msb[k+1] = msb_p;
      assign src_cin[k+1] = cin_p;
    end else begin : g_last
      logic cout;

      // Overflow covers both the adder carry-out and the carry bit shifted past W-1.
      assign cout = seg[SEG] | src_msb[k];

      // ---- final stage boundary: output register ----
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p <= 1'b0;
          acc_p <= '0;
          cin_p <= 1'b0;
        end else if (rdy[k]) begin
          vld_p <= src_v[k];
          if (src_v[k]) begin
            acc_p <= sat_fn(put_seg(src_acc[k], seg[SEG-1:0], k), cout);
            cin_p <= cout;
          end
        end
      end

      assign bus.out_valid = vld_p;
      assign bus.out_data  = acc_p;
      assign bus.out_cout  = cin_p;
    end
  end

endmodule

// File: tb/tb_cs_resolve_pipe.sv
// Directed and randomized checks of cs_resolve_pipe at SEG=8 (4 stages) and SEG=32 (1 stage).
module tb_cs_resolve_pipe;

`ifdef CS_RESOLVE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vld  [2];
  logic [31:0] s    [2];
  logic [31:0] c    [2];
  logic        ordy [2];
  logic        irdy [2];
  logic        ovld [2];
  logic [31:0] odat [2];
  logic        ocout[2];

  cs_resolve_pipe_if #(.W(32)) ifc0 ();
  cs_resolve_pipe_if #(.W(32)) ifc1 ();

  assign ifc0.in_valid  = vld[0];
  assign ifc0.in_sum    = s[0];
  assign ifc0.in_carry  = c[0];
  assign ifc0.out_ready = ordy[0];
  assign irdy[0]  = ifc0.in_ready;
  assign ovld[0]  = ifc0.out_valid;
  assign odat[0]  = ifc0.out_data;
  assign ocout[0] = ifc0.out_cout;

  assign ifc1.in_valid  = vld[1];
  assign ifc1.in_sum    = s[1];
  assign ifc1.in_carry  = c[1];
  assign ifc1.out_ready = ordy[1];
  assign irdy[1]  = ifc1.in_ready;
  assign ovld[1]  = ifc1.out_valid;
  assign odat[1]  = ifc1.out_data;
  assign ocout[1] = ifc1.out_cout;

  cs_resolve_pipe #(.W(32), .SEG(8))  u_dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
  cs_resolve_pipe #(.W(32), .SEG(32)) u_dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact W+2-bit value of sum + (carry << 1).
  function automatic logic [32:0] ref_out(input logic [31:0] rs, input logic [31:0] rc);
    logic [33:0] v;
    logic        co;
    v  = {2'b00, rs} + {1'b0, rc, 1'b0};
    co = |v[33:32];
    return {co, (SAT && co) ? 32'hFFFF_FFFF : v[31:0]};
  endfunction

  typedef struct {
    logic [31:0] sum;
    logic [31:0] carry;
    logic [31:0] data;
    logic        cout;
  } vec_t;

  vec_t tv [9];
  logic [32:0] sb0 [$];
  logic [32:0] sb1 [$];

  task automatic sb_push(input int d, input logic [32:0] v);
    if (d == 0) sb0.push_back(v);
    else        sb1.push_back(v);
  endtask

  task automatic sb_check(input int d);
    logic [32:0] e;
    int sz;
    sz = (d == 0) ? sb0.size() : sb1.size();
    if (sz == 0) begin
      chk("rand_unexpected_out", {63'd0, ovld[d]}, 64'd0);
    end else begin
      e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
      chk(d == 0 ? "rand_seg8" : "rand_seg32", {31'd0, ocout[d], odat[d]}, {31'd0, e});
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, got, sent, spur;
    logic [31:0] expd;

    tv[0] = '{32'h0000_00FF, 32'h0000_0001, 32'h0000_0101, 1'b0};
    tv[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1};
    tv[2] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    tv[3] = '{32'h1234_5678, 32'h0000_0010, 32'h1234_5698, 1'b0};
    tv[4] = '{32'h0000_FFFF, 32'h0000_8000, 32'h0001_FFFF, 1'b0};
    tv[5] = '{32'h7FFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0};
    tv[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
    tv[7] = '{32'h00FF_00FF, 32'h0080_0080, 32'h01FF_01FF, 1'b0};
    tv[8] = '{32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};

    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; s[d] = '0; c[d] = '0; ordy[d] = 1'b1;
    end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", {63'd0, ovld[0]}, 64'd0);
    chk("reset_in_ready", {63'd0, irdy[0]}, 64'd1);
    chk("reset_out_data", {32'd0, odat[0]}, 64'd0);
    chk("reset_out_cout", {63'd0, ocout[0]}, 64'd0);
    chk("reset_in_ready_seg32", {63'd0, irdy[1]}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors: single beats, latency and value
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      vld[0] = 1'b1; s[0] = tv[i].sum; c[0] = tv[i].carry;
      #1 chk("accept_ready", {63'd0, irdy[0]}, 64'd1);
      @(negedge clk);
      vld[0] = 1'b0; s[0] = $urandom; c[0] = $urandom;
      lat = 0;
      for (int cy = 1; cy <= 20; cy++) begin
        #1;
        if (ovld[0]) begin
          lat = cy;
          break;
        end
        @(negedge clk);
        s[0] = $urandom; c[0] = $urandom;
      end
      expd = (SAT && tv[i].cout) ? 32'hFFFF_FFFF : tv[i].data;
      chk("vec_latency", 64'(lat), 64'd4);
      chk("vec_data", {32'd0, odat[0]}, {32'd0, expd});
      chk("vec_cout", {63'd0, ocout[0]}, {63'd0, tv[i].cout});
    end

    // Backpressure: 8 beats of sum=carry=n, sink stalled in cycles 3..9
    got = 0; sent = 0;
    for (int cy = 0; cy < 60 && got < 8; cy++) begin
      @(negedge clk);
      ordy[0] = !(cy >= 3 && cy <= 9);
      vld[0]  = (sent < 8);
      s[0]    = (sent < 8) ? 32'(sent + 1) : $urandom;
      c[0]    = (sent < 8) ? 32'(sent + 1) : $urandom;
      #1;
      if (cy >= 4 && cy <= 9) chk("bp_full_in_ready", {63'd0, irdy[0]}, 64'd0);
      if (cy == 10) chk("bp_release_in_ready", {63'd0, irdy[0]}, 64'd1);
      if (ovld[0]) begin
        chk("bp_data", {32'd0, odat[0]}, 64'(3 * (got + 1)));
        chk("bp_cout", {63'd0, ocout[0]}, 64'd0);
        if (ordy[0]) got++;
      end
      if (vld[0] && irdy[0]) sent++;
    end
    chk("bp_out_count", 64'(got), 64'd8);
    chk("bp_in_count", 64'(sent), 64'd8);

    // Reset with three beats in flight
    ordy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vld[0] = 1'b1; s[0] = 32'(i + 5); c[0] = 32'(i + 5);
    end
    @(negedge clk);
    vld[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", {63'd0, ovld[0]}, 64'd0);
    chk("rst_mid_out_data", {32'd0, odat[0]}, 64'd0);
    chk("rst_mid_out_cout", {63'd0, ocout[0]}, 64'd0);
    chk("rst_mid_in_ready", {63'd0, irdy[0]}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    spur = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (ovld[0]) spur++;
    end
    chk("rst_no_output_after", 64'(spur), 64'd0);
    chk("rst_after_in_ready", {63'd0, irdy[0]}, 64'd1);

    // Single-stage build: one cycle latency
    @(negedge clk);
    vld[1] = 1'b1; s[1] = 32'h1234_5678; c[1] = 32'h0000_0010;
    @(negedge clk);
    vld[1] = 1'b0; s[1] = $urandom; c[1] = $urandom;
    #1;
    chk("seg32_valid", {63'd0, ovld[1]}, 64'd1);
    chk("seg32_data", {32'd0, odat[1]}, 64'h1234_5698);
    chk("seg32_cout", {63'd0, ocout[1]}, 64'd0);

    // Random sweep with random stalls on both builds
    for (int cy = 0; cy < 400; cy++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vld[d]  = (cy < 360) && ($urandom_range(3) != 0);
        s[d]    = $urandom;
        c[d]    = $urandom;
        ordy[d] = (cy >= 360) || ($urandom_range(9) < 7);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        if (ovld[d] && ordy[d]) sb_check(d);
        if (vld[d] && irdy[d]) sb_push(d, ref_out(s[d], c[d]));
      end
    end
    chk("rand_drain_seg8", 64'(sb0.size()), 64'd0);
    chk("rand_drain_seg32", 64'(sb1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
